uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
- Downstream stage of the UART receive path.
- Consumes the cleaned serial stream `rxd` and the oversample tick `baud_tick` produced by the oversampling stage.
- Detects start bits, samples data bits at mid-bit (LSB first) and checks the stop bit.
- Presents each completed byte to the host through a valid/ack handshake, and flags framing and overrun errors.

Parameters:
- DATA_BITS, 8: data bits per frame (5..8).
- OVERSAMPLE, 8: baud_tick pulses per bit period; must be even, ≥4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rxd  in  1  cleaned serial input, idle high
- baud_tick  in  1  oversample strobe, one clk wide
- rd_ack  in  1  host consumed data; clears data_valid
- data  out  DATA_BITS  last good received byte
- data_valid  out  1  level; a byte is waiting for the host
- frame_err  out  1  one-clk pulse; stop bit sampled low
- overrun_err  out  1  one-clk pulse; byte completed while data_valid=1 and no rd_ack
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, tick_cnt=0, bit_cnt=0, shift=0, data=0, data_valid=0, frame_err=0, overrun_err=0, busy=0.
  - Reset mid-frame aborts the frame; no flags are raised.
- Timing: all state and counter actions occur only on clk edges where baud_tick=1, except the rd_ack handling and pulse clearing.
- IDLE:
  - On baud_tick with rxd=0, go to START with tick_cnt=0.
- START:
  - On baud_tick with tick_cnt==OVERSAMPLE/2-1:
    - rxd=0: go to DATA, tick_cnt=0, bit_cnt=0.
    - rxd=1: glitch; return to IDLE with no flag.
  - On other baud_ticks: tick_cnt++.
- DATA:
  - On baud_tick with tick_cnt==OVERSAMPLE-1: shift = {rxd, shift[DATA_BITS-1:1]}, tick_cnt=0, bit_cnt++.
  - When bit_cnt==DATA_BITS-1 at that point, go to STOP (or PARITY when the optional feature is compiled in).
  - On other baud_ticks: tick_cnt++.
- STOP:
  - On baud_tick with tick_cnt==OVERSAMPLE-1, go to IDLE and evaluate:
    - rxd=1 and (data_valid=0 or rd_ack=1): data<=shift, data_valid<=1 on the next edge.
    - rxd=1 and data_valid=1 and rd_ack=0: data unchanged, byte dropped, overrun_err pulses.
    - rxd=0: frame_err pulses; data and data_valid unchanged.
  - IDLE is re-entered at mid-stop, so a start bit immediately following is detected.
- rd_ack:
  - rd_ack=1 clears data_valid on the next edge.
  - If it coincides with completion of a good byte, the new byte loads and data_valid stays 1.
  - rd_ack with data_valid=0 is ignored.
- Latency: data_valid rises one clk after the mid-stop baud_tick.
- Widths: tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS)+1 bits; counters never wrap in normal operation.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a parameter PARITY_ODD (default 0 = even) and an output parity_err (1-bit pulse, reset 0).
  - Adds a PARITY state between DATA and STOP, sampled after OVERSAMPLE ticks.
  - On mismatch, parity_err pulses at the STOP evaluation and the byte is not loaded.
  - frame_err takes precedence; both may pulse together.
- Undefined:
  - No PARITY state and no parity_err port; DATA goes directly to STOP.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP}.
  - Constants DEF_DATA_BITS=8 and DEF_OVERSAMPLE=8.
- One sub-module, uart_rx_bit_timer:
  - Owns tick_cnt and reports half_bit / full_bit strobes from baud_tick plus a clear input.
  - The deframer FSM owns bit_cnt, shift and the output registers.

Test Plan:
- Byte with delay: baud_tick every 4 clk, send 0xA5 (frame 0,1,0,1,0,0,1,0,1,1) → data=0xA5, data_valid=1, frame_err=0, busy low at mid-stop.
- Glitch: rxd low for 2 ticks then high → stays in IDLE/START only, returns to IDLE, data_valid=0, no flags.
- Framing error: 0x3C sent with stop bit 0 → frame_err one-clk pulse, data_valid=0, data=0.
- Overrun: 0x11 received without ack, then 0x22 → overrun_err pulse, data=0x11. Repeat with rd_ack on the completion edge → data=0x22, data_valid=1, no overrun.
- Back-to-back: 0x55 then 0xAA with no idle gap, ack after each → both bytes delivered.
- Reset mid-frame: rst after 4 data bits → all outputs 0; the next full 0x0F frame is received correctly.
- Parity (UART_RX_PARITY_EN): 0x07 with even parity bit 0 → parity_err pulse, byte not loaded.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encoding and default parameters for the UART
//            receive deframer slice.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_deframer_if.sv
// ============================================================================
// Module   : uart_rx_deframer_if
// Brief    : Host-side handshake and status bundle of the UART deframer.
//            parity_err exists only when UART_RX_PARITY_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_rx_deframer_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);

  logic                 rd_ack;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  // Host side: acknowledges bytes and observes status
  modport master (
    output rd_ack,
    input  data,
    input  data_valid,
    input  frame_err,
    input  overrun_err,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  busy
  );

  // Deframer side
  modport slave (
    input  rd_ack,
    output data,
    output data_valid,
    output frame_err,
    output overrun_err,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output busy
  );

endinterface : uart_rx_deframer_if

`default_nettype wire

// File: rtl/uart_rx_bit_timer.sv
// ============================================================================
// Module   : uart_rx_bit_timer
// Brief    : Counts oversample ticks inside a bit and strobes at the half-bit
//            and full-bit points; clear restarts the count on a tick.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic baud_tick,
  input  wire logic clear,
  output logic      half_bit,
  output logic      full_bit
);

  localparam int                 c_cnt_w     = $clog2(OVERSAMPLE);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full_last = c_cnt_w'(OVERSAMPLE - 1);

  logic [c_cnt_w-1:0] r_tick_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (baud_tick) begin
      r_tick_cnt <= clear ? '0 : r_tick_cnt + 1'b1;
    end
  end

  assign half_bit = baud_tick && (r_tick_cnt == c_half_last);
  assign full_bit = baud_tick && (r_tick_cnt == c_full_last);

endmodule : uart_rx_bit_timer

`default_nettype wire

// File: rtl/uart_rx_deframer.sv
// ============================================================================
// Module   : uart_rx_deframer
// Brief    : UART receive deframer: start detect, mid-bit LSB-first sampling,
//            stop check, valid/ack byte handoff with framing/overrun flags.
// Options  : UART_RX_PARITY_EN adds a parity bit, PARITY_ODD and parity_err.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          rxd,
  input  wire logic          baud_tick,
  uart_rx_deframer_if.slave  host
);

  localparam int                    c_bit_cnt_w = $clog2(DATA_BITS) + 1;
  localparam logic [c_bit_cnt_w-1:0] c_last_bit = c_bit_cnt_w'(DATA_BITS - 1);

  state_t                 r_state;
  logic [c_bit_cnt_w-1:0] r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_data_valid;
  logic                   r_frame_err;
  logic                   r_overrun_err;
  logic                   r_busy;

  logic w_half_bit;
  logic w_full_bit;
  logic w_clear;
  logic w_par_ok;

  // Tick count is held at zero while idle and restarts at every bit boundary
  assign w_clear = (r_state == IDLE)
                 || ((r_state == START) && w_half_bit)
                 || w_full_bit;

  uart_rx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .clear     (w_clear),
    .half_bit  (w_half_bit),
    .full_bit  (w_full_bit)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;

  assign w_par_ok = (r_par_bit == ((^r_shift) ^ PARITY_ODD));
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
      r_busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit     <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
      // A byte loaded at stop below overrides this clear
      if (host.rd_ack) begin
        r_data_valid <= 1'b0;
      end

      if (baud_tick) begin
        case (r_state)
          IDLE: begin
            if (!rxd) begin
              r_state <= START;
              r_busy  <= 1'b1;
            end
          end

          START: begin
            if (w_half_bit) begin
              if (!rxd) begin
                r_state   <= DATA;
                r_bit_cnt <= '0;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
          end

          DATA: begin
            if (w_full_bit) begin
              r_shift   <= {rxd, r_shift[DATA_BITS-1:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (w_full_bit) begin
              r_par_bit <= rxd;
              r_state   <= STOP;
            end
          end
`endif

          STOP: begin
            if (w_full_bit) begin
              // Leaving at mid-stop lets a following start bit be caught
              r_state <= IDLE;
              r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (!w_par_ok) begin
                r_parity_err <= 1'b1;
              end
`endif
              if (!rxd) begin
                r_frame_err <= 1'b1;
              end else if (w_par_ok) begin
                if (!r_data_valid || host.rd_ack) begin
                  r_data       <= r_shift;
                  r_data_valid <= 1'b1;
                end else begin
                  r_overrun_err <= 1'b1;
                end
              end
            end
          end

          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign host.data        = r_data;
  assign host.data_valid  = r_data_valid;
  assign host.frame_err   = r_frame_err;
  assign host.overrun_err = r_overrun_err;
  assign host.busy        = r_busy;
`ifdef UART_RX_PARITY_EN
  assign host.parity_err  = r_parity_err;
`endif

endmodule : uart_rx_deframer

`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
// ============================================================================
// Module   : tb_uart_rx_deframer
// Brief    : Self-checking bench for uart_rx_deframer (default build).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_deframer;

  localparam int c_os          = 8;
  localparam int c_db          = 8;
  localparam int c_div         = 4;
  localparam int c_frame_ticks = c_os * (c_db + 2);
  localparam int c_stop_tick   = c_os / 2 + c_os * (c_db + 1);

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic rxd       = 1'b1;
  logic baud_tick = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_deframer_if #(.DATA_BITS(c_db)) host_if ();

  uart_rx_deframer #(
    .DATA_BITS  (c_db),
    .OVERSAMPLE (c_os)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .baud_tick (baud_tick),
    .host      (host_if)
  );

  always #5 clk = ~clk;

  // baud_tick changes just after a rising edge, one clk high every c_div clks
  int div_cnt = 0;
  always @(posedge clk) begin
    #1;
    div_cnt   = (div_cnt == c_div - 1) ? 0 : div_cnt + 1;
    baud_tick = (div_cnt == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse counters and one-clk width checks on the error flags
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      fe_prev = 1'b0;
      ov_prev = 1'b0;
    end else begin
      if (host_if.frame_err) begin
        fe_cnt++;
        check("frame_err_one_clk", 32'(fe_prev), 32'd0);
      end
      if (host_if.overrun_err) begin
        ov_cnt++;
        check("overrun_err_one_clk", 32'(ov_prev), 32'd0);
      end
      fe_prev = host_if.frame_err;
      ov_prev = host_if.overrun_err;
    end
  end

  // Reference model of the host-visible state
  logic [7:0] m_data = 8'h00;
  logic       m_dv   = 1'b0;
  int         m_fe   = 0;
  int         m_ov   = 0;

  // Returns at the falling edge just before the next rising edge that carries a tick
  task automatic next_tick();
    int guard;
    guard = 0;
    @(negedge clk);
    host_if.rd_ack = 1'b0;
    while (!baud_tick && guard < 4 * c_div) begin
      @(negedge clk);
      guard++;
    end
    if (!baud_tick) check("baud_tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_gap(input int ticks, input logic ack);
    for (int t = 0; t < ticks; t++) begin
      next_tick();
      rxd = 1'b1;
      if (ack && t == 0) host_if.rd_ack = 1'b1;
    end
    if (ack && ticks > 0) m_dv = 1'b0;
  endtask

  // ack_tick: frame tick index at which rd_ack is pulsed (-1 = none)
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_tick);
    logic [9:0] bits;
    logic       ack_done;
    logic       dv_at_stop;
    bits     = {stop, b, 1'b0};
    ack_done = (ack_tick == c_stop_tick);
    if (!stop) begin
      m_fe++;
      if (ack_done) m_dv = 1'b0;
    end else if (!m_dv || ack_done) begin
      m_data = b;
      m_dv   = 1'b1;
    end else begin
      m_ov++;
    end
    dv_at_stop = m_dv;
    if (ack_tick > c_stop_tick) m_dv = 1'b0;

    for (int t = 0; t < c_frame_ticks; t++) begin
      next_tick();
      if (t % c_os == 0) rxd = bits[t / c_os];
      if (t == ack_tick) host_if.rd_ack = 1'b1;
      @(posedge clk);
      #2;
      if (t == c_os * 4) check("busy_in_frame", 32'(host_if.busy), 32'd1);
      if (t == c_stop_tick) begin
        check("busy_after_mid_stop", 32'(host_if.busy), 32'd0);
        check("data_valid_after_mid_stop", 32'(host_if.data_valid), 32'(dv_at_stop));
      end
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         ack_tick;
    int         gap;
    logic       pre_ack;
    logic [7:0] exp_data;
    logic       exp_dv;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] pb;
    int         fe0;
    int         ov0;
    int         r;
    int         ack_sel;

    //           byte   stop  ack  gap  pre    data   dv    fe  ov
    tbl[0] = '{8'h3C, 1'b0, -1,  2, 1'b0, 8'h00, 1'b0, 1, 0};
    tbl[1] = '{8'hA5, 1'b1, -1,  3, 1'b0, 8'hA5, 1'b1, 0, 0};
    tbl[2] = '{8'h11, 1'b1, -1,  1, 1'b1, 8'h11, 1'b1, 0, 0};
    tbl[3] = '{8'h22, 1'b1, -1,  0, 1'b0, 8'h11, 1'b1, 0, 1};
    tbl[4] = '{8'h22, 1'b1, 76,  2, 1'b0, 8'h22, 1'b1, 0, 0};
    tbl[5] = '{8'h55, 1'b1, 78,  1, 1'b1, 8'h55, 1'b0, 0, 0};
    tbl[6] = '{8'hAA, 1'b1, 78,  0, 1'b0, 8'hAA, 1'b0, 0, 0};
    tbl[7] = '{8'hC3, 1'b0, -1,  2, 1'b0, 8'hAA, 1'b0, 1, 0};
    tbl[8] = '{8'h81, 1'b1, -1,  0, 1'b0, 8'h81, 1'b1, 0, 0};
    tbl[9] = '{8'h7E, 1'b0, 76,  1, 1'b0, 8'h81, 1'b0, 1, 0};

    host_if.rd_ack = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check("reset_data", 32'(host_if.data), 32'h0);
    check("reset_data_valid", 32'(host_if.data_valid), 32'd0);
    check("reset_frame_err", 32'(host_if.frame_err), 32'd0);
    check("reset_overrun_err", 32'(host_if.overrun_err), 32'd0);
    check("reset_busy", 32'(host_if.busy), 32'd0);

    // Glitch: two ticks low, then high; mid-start sample sees 1
    idle_gap(3, 1'b0);
    for (int t = 0; t < c_os; t++) begin
      next_tick();
      rxd = (t < 2) ? 1'b0 : 1'b1;
      @(posedge clk);
      #2;
      if (t == 2) check("glitch_busy_in_start", 32'(host_if.busy), 32'd1);
      if (t == 5) check("glitch_back_to_idle", 32'(host_if.busy), 32'd0);
    end
    check("glitch_data_valid", 32'(host_if.data_valid), 32'd0);
    check("glitch_no_frame_err", 32'(fe_cnt), 32'd0);
    check("glitch_no_overrun", 32'(ov_cnt), 32'd0);

    for (int i = 0; i < 10; i++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      idle_gap(tbl[i].gap, tbl[i].pre_ack);
      send_frame(tbl[i].b, tbl[i].stop, tbl[i].ack_tick);
      check($sformatf("tbl%0d_data", i), 32'(host_if.data), 32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_data_valid", i), 32'(host_if.data_valid), 32'(tbl[i].exp_dv));
      check($sformatf("tbl%0d_frame_err_pulses", i), 32'(fe_cnt - fe0), 32'(tbl[i].exp_fe));
      check($sformatf("tbl%0d_overrun_pulses", i), 32'(ov_cnt - ov0), 32'(tbl[i].exp_ov));
    end

    // Reset after start plus four data bits aborts silently
    pb = {1'b1, 8'h5A, 1'b0};
    for (int t = 0; t < 5 * c_os; t++) begin
      next_tick();
      if (t % c_os == 0) rxd = pb[t / c_os];
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    m_data = 8'h00;
    m_dv   = 1'b0;
    check("midrst_data", 32'(host_if.data), 32'h0);
    check("midrst_data_valid", 32'(host_if.data_valid), 32'd0);
    check("midrst_busy", 32'(host_if.busy), 32'd0);
    check("midrst_frame_err", 32'(host_if.frame_err), 32'd0);
    check("midrst_overrun_err", 32'(host_if.overrun_err), 32'd0);
    idle_gap(4, 1'b0);
    send_frame(8'h0F, 1'b1, -1);
    check("after_rst_data", 32'(host_if.data), 32'h0F);
    check("after_rst_data_valid", 32'(host_if.data_valid), 32'd1);
    check("after_rst_frame_err_total", 32'(fe_cnt), 32'(m_fe));

    // Randomised traffic against the model
    for (int i = 0; i < 40; i++) begin
      r       = $urandom_range(0, 5);
      ack_sel = $urandom_range(0, 2);
      idle_gap($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      send_frame(8'($urandom), (r != 0),
                 (ack_sel == 0) ? -1 : ((ack_sel == 1) ? c_stop_tick : c_stop_tick + 2));
      check($sformatf("rnd%0d_data", i), 32'(host_if.data), 32'(m_data));
      check($sformatf("rnd%0d_data_valid", i), 32'(host_if.data_valid), 32'(m_dv));
      check($sformatf("rnd%0d_frame_err_total", i), 32'(fe_cnt), 32'(m_fe));
      check($sformatf("rnd%0d_overrun_total", i), 32'(ov_cnt), 32'(m_ov));
    end

    idle_gap(2, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_deframer

`default_nettype wire
